// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between inst and data requesters with an in-order source-ID FIFO.
// Optional ARB_RR_EN: round-robin on contention instead of fixed data-over-inst priority.
module sram_req_arbiter #(
  parameter int OUTSTD_DEPTH = 4,
  parameter int PTR_W        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [31:0]       inst_addr,
  input  logic [31:0]       inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata
);

  localparam logic [0:0] UNLOCKED = 1'b0;
  localparam logic [0:0] LOCKED   = 1'b1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(OUTSTD_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [0:0]              state;
  logic                    grant_src;
  logic                    gnt_vld;
  logic                    gnt_src;
  logic                    src_req;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    head;
  logic [PTR_W:0]          count;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [OUTSTD_DEPTH-1:0] src_fifo;

`ifdef ARB_RR_EN
  logic last_src;
`endif

  // While locked the pending request must be held on the port, whoever else asks.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = 1'b0;
    if (state == LOCKED) begin
      gnt_vld = 1'b1;
      gnt_src = grant_src;
    end else if (inst_req && data_req) begin
      gnt_vld = 1'b1;
`ifdef ARB_RR_EN
      gnt_src = ~last_src;
`else
      gnt_src = 1'b1;
`endif
    end else if (data_req) begin
      gnt_vld = 1'b1;
      gnt_src = 1'b1;
    end else if (inst_req) begin
      gnt_vld = 1'b1;
      gnt_src = 1'b0;
    end
  end

  assign src_req = gnt_src ? data_req : inst_req;
  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign mem_req = gnt_vld & src_req & ~full & ~reset;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (gnt_vld) begin
      if (gnt_src) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  assign push = mem_req & mem_addr_ok;
  assign pop  = mem_data_ok & ~empty & ~reset;
  assign head = src_fifo[rd_ptr];

  assign inst_addr_ok = push & ~gnt_src;
  assign data_addr_ok = push & gnt_src;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNLOCKED;
      grant_src <= 1'b0;
    end else begin
      case (state)
        UNLOCKED: begin
          if (mem_req && !mem_addr_ok) begin
            state     <= LOCKED;
            grant_src <= gnt_src;
          end
        end
        default: begin
          // A requester that withdraws its pending request releases the lock.
          if (!src_req || push) state <= UNLOCKED;
        end
      endcase
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) last_src <= 1'b0;
    else if (push) last_src <= gnt_src;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) src_fifo[wr_ptr] <= gnt_src;
  end

  // Full gating uses the registered count, so a same-cycle pop never frees a slot early.
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed vector bench for sram_req_arbiter in its default (fixed-priority) build.
module tb_sram_req_arbiter;

  localparam logic [31:0] I_ADDR = 32'h1c000000;
  localparam logic [31:0] I_WD   = 32'h11111111;
  localparam logic [31:0] D_ADDR = 32'h80000000;
  localparam logic [31:0] D_WD   = 32'hdeadbeef;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  sram_req_arbiter #(.OUTSTD_DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // src: 0 = no grant (payload zero), 1 = inst payload, 2 = data payload, 3 = not checked
  typedef struct {
    logic        ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic        mreq, iaok, daok, idok, ddok;
    logic [1:0]  src;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs[NV];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok, input logic [31:0] rd);
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
  endtask

  task automatic chk_hs(input string tag, input int idx, input logic mr, input logic ia, input logic da,
                        input logic id, input logic dd);
    chk({tag, ".mem_req"}, idx, {31'd0, mem_req}, {31'd0, mr});
    chk({tag, ".inst_addr_ok"}, idx, {31'd0, inst_addr_ok}, {31'd0, ia});
    chk({tag, ".data_addr_ok"}, idx, {31'd0, data_addr_ok}, {31'd0, da});
    chk({tag, ".inst_data_ok"}, idx, {31'd0, inst_data_ok}, {31'd0, id});
    chk({tag, ".data_data_ok"}, idx, {31'd0, data_data_ok}, {31'd0, dd});
  endtask

  initial begin
    //            ireq dreq aok dok rdata            mreq iaok daok idok ddok src
    vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,         1'b1,1'b0,1'b1,1'b0,1'b0,2'd2};
    vecs[1]  = '{1'b1,1'b1,1'b1,1'b1,32'h12345678,  1'b1,1'b0,1'b1,1'b0,1'b1,2'd2};
    vecs[2]  = '{1'b1,1'b1,1'b1,1'b1,32'h12345678,  1'b1,1'b0,1'b1,1'b0,1'b1,2'd2};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,32'h12345678,  1'b0,1'b0,1'b0,1'b0,1'b1,2'd0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b0,1'b0,1'b0,1'b0,2'd1};
    vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,         1'b1,1'b0,1'b0,1'b0,1'b0,2'd1};
    vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,         1'b1,1'b0,1'b0,1'b0,1'b0,2'd1};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,1'b0,1'b0,2'd1};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,         1'b1,1'b0,1'b1,1'b0,1'b0,2'd2};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,32'ha1a1a1a1,  1'b0,1'b0,1'b0,1'b1,1'b0,2'd0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,32'ha2a2a2a2,  1'b0,1'b0,1'b0,1'b0,1'b1,2'd0};
    vecs[11] = '{1'b0,1'b1,1'b1,1'b0,32'h0,         1'b1,1'b0,1'b1,1'b0,1'b0,2'd2};
    vecs[12] = '{1'b1,1'b0,1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,1'b0,1'b0,2'd1};
    vecs[13] = '{1'b0,1'b1,1'b1,1'b0,32'h0,         1'b1,1'b0,1'b1,1'b0,1'b0,2'd2};
    vecs[14] = '{1'b1,1'b0,1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,1'b0,1'b0,2'd1};
    vecs[15] = '{1'b1,1'b1,1'b1,1'b0,32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0,2'd2};
    vecs[16] = '{1'b0,1'b1,1'b1,1'b1,32'hb1b1b1b1,  1'b0,1'b0,1'b0,1'b0,1'b1,2'd2};
    vecs[17] = '{1'b0,1'b1,1'b1,1'b0,32'h0,         1'b1,1'b0,1'b1,1'b0,1'b0,2'd2};
    vecs[18] = '{1'b0,1'b0,1'b0,1'b1,32'hc1c1c1c1,  1'b0,1'b0,1'b0,1'b1,1'b0,2'd0};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b1,32'hc2c2c2c2,  1'b0,1'b0,1'b0,1'b0,1'b1,2'd0};
    vecs[20] = '{1'b1,1'b0,1'b1,1'b1,32'hc3c3c3c3,  1'b1,1'b1,1'b0,1'b1,1'b0,2'd1};
    vecs[21] = '{1'b0,1'b0,1'b0,1'b1,32'hc4c4c4c4,  1'b0,1'b0,1'b0,1'b0,1'b1,2'd0};
    vecs[22] = '{1'b0,1'b0,1'b0,1'b1,32'hc5c5c5c5,  1'b0,1'b0,1'b0,1'b1,1'b0,2'd0};
    vecs[23] = '{1'b0,1'b0,1'b0,1'b1,32'hc6c6c6c6,  1'b0,1'b0,1'b0,1'b0,1'b0,2'd0};
    vecs[24] = '{1'b1,1'b0,1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,1'b0,1'b0,2'd1};
    vecs[25] = '{1'b0,1'b1,1'b1,1'b0,32'h0,         1'b1,1'b0,1'b1,1'b0,1'b0,2'd2};
    vecs[26] = '{1'b1,1'b0,1'b1,1'b0,32'h0,         1'b1,1'b1,1'b0,1'b0,1'b0,2'd1};
    vecs[27] = '{1'b0,1'b0,1'b0,1'b1,32'he1e1e1e1,  1'b0,1'b0,1'b0,1'b1,1'b0,2'd0};
    vecs[28] = '{1'b0,1'b0,1'b0,1'b1,32'he2e2e2e2,  1'b0,1'b0,1'b0,1'b0,1'b1,2'd0};
    vecs[29] = '{1'b0,1'b0,1'b0,1'b1,32'he3e3e3e3,  1'b0,1'b0,1'b0,1'b1,1'b0,2'd0};
    vecs[30] = '{1'b0,1'b0,1'b0,1'b1,32'he4e4e4e4,  1'b0,1'b0,1'b0,1'b0,1'b0,2'd0};
    vecs[31] = '{1'b1,1'b0,1'b0,1'b0,32'h0,         1'b1,1'b0,1'b0,1'b0,1'b0,2'd1};
    vecs[32] = '{1'b0,1'b1,1'b0,1'b0,32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0,2'd3};
    vecs[33] = '{1'b0,1'b1,1'b1,1'b0,32'h0,         1'b1,1'b0,1'b1,1'b0,1'b0,2'd2};
    vecs[34] = '{1'b0,1'b0,1'b0,1'b1,32'hf1f1f1f1,  1'b0,1'b0,1'b0,1'b0,1'b1,2'd0};

    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_addr = I_ADDR; inst_wdata = I_WD;
    data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'h3; data_addr = D_ADDR; data_wdata = D_WD;

    // Reset cycle with every input active: nothing may be granted or returned.
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
    chk_hs("reset", -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    for (int k = 0; k < NV; k++) begin
      @(posedge clk);
      #1;
      drive(vecs[k].ireq, vecs[k].dreq, vecs[k].aok, vecs[k].dok, vecs[k].rdata);
      @(negedge clk);
      chk_hs("vec", k, vecs[k].mreq, vecs[k].iaok, vecs[k].daok, vecs[k].idok, vecs[k].ddok);
      if (vecs[k].idok) chk("vec.inst_rdata", k, inst_rdata, vecs[k].rdata);
      if (vecs[k].ddok) chk("vec.data_rdata", k, data_rdata, vecs[k].rdata);
      case (vecs[k].src)
        2'd0: begin
          chk("vec.mem_addr", k, mem_addr, 32'h0);
          chk("vec.mem_wdata", k, mem_wdata, 32'h0);
        end
        2'd1: begin
          chk("vec.mem_addr", k, mem_addr, I_ADDR);
          chk("vec.mem_wdata", k, mem_wdata, I_WD);
          chk("vec.mem_ctl", k, {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, 1'b0, 2'd2, 4'hf});
        end
        2'd2: begin
          chk("vec.mem_addr", k, mem_addr, D_ADDR);
          chk("vec.mem_wdata", k, mem_wdata, D_WD);
          chk("vec.mem_ctl", k, {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, 1'b1, 2'd1, 4'h3});
        end
        default: ;
      endcase
    end

    // Reset with two transactions outstanding; later beats must be dropped.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk_hs("pre_rst", k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h55555555);
    @(negedge clk);
    chk_hs("mid_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h66666666);
      @(negedge clk);
      chk_hs("stray", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk_hs("post_rst", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h77777777);
    @(negedge clk);
    chk_hs("post_rst", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst.inst_rdata", 1, inst_rdata, 32'h77777777);

    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
